// File: rtl/cla_adder_16_pkg.sv
// Shared widths and bundle types for the 16-bit two-level
// carry-lookahead adder.
package cla_adder_16_pkg;

   localparam int DATA_W = 16;
   localparam int GRP_W  = 4;
   localparam int GRP_N  = DATA_W / GRP_W;

   // The adder has no carry input; the lookahead terms still carry it
   localparam logic CARRY_IN = 1'b0;

   typedef struct packed {
      logic g;
      logic p;
   } grp_pg_t;

endpackage

// File: rtl/cla_adder_16_cla_4bit.sv
// One 4-bit lookahead group: sum bits plus group generate
// and propagate for the second-level carry unit.
module cla_4bit
   import cla_adder_16_pkg::*;
(
   input  logic [GRP_W-1:0] a,
   input  logic [GRP_W-1:0] b,
   input  logic             cin,
   output logic [GRP_W-1:0] s,
   output logic             G,
   output logic             P
);

   logic [GRP_W-1:0] g;
   logic [GRP_W-1:0] p;
   logic [GRP_W-1:0] c;

   always_comb begin
      g = a & b;
      p = a ^ b;
   end

   // Internal carries are flat lookahead terms, not a ripple chain
   always_comb begin
      c    = '0;
      c[0] = cin;
      c[1] = g[0]
           | (p[0] & cin);
      c[2] = g[1]
           | (p[1] & g[0])
           | (p[1] & p[0] & cin);
      c[3] = g[2]
           | (p[2] & g[1])
           | (p[2] & p[1] & g[0])
           | (p[2] & p[1] & p[0] & cin);
   end

   always_comb begin
      s = p ^ c;
      G = g[3]
        | (p[3] & g[2])
        | (p[3] & p[2] & g[1])
        | (p[3] & p[2] & p[1] & g[0]);
      P = &p;
   end

endmodule

// File: rtl/cla_adder_16.sv
// 16-bit two-level CLA: four lookahead groups, second-level
// carry unit, signed overflow and a registered result copy.
module cla_adder_16
   import cla_adder_16_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] A,
   input  logic [DATA_W-1:0] B,
   output logic [DATA_W-1:0] Sum,
   output logic              Cout,
   output logic              Ovfl,
   output logic [DATA_W-1:0] Sum_q,
   output logic              Cout_q,
   output logic              Ovfl_q
);

   grp_pg_t [GRP_N-1:0] pg;
   logic    [GRP_N-1:0] gc;
   logic    [DATA_W-1:0] sum_w;

   for (genvar i = 0; i < GRP_N; i++) begin : g_grp
      cla_4bit u_grp (
         .a   (A[i*GRP_W +: GRP_W]),
         .b   (B[i*GRP_W +: GRP_W]),
         .cin (gc[i]),
         .s   (sum_w[i*GRP_W +: GRP_W]),
         .G   (pg[i].g),
         .P   (pg[i].p)
      );
   end

   // Every group carry comes straight from group G/P terms
   always_comb begin
      gc    = '0;
      gc[0] = CARRY_IN;
      gc[1] = pg[0].g
            | (pg[0].p & CARRY_IN);
      gc[2] = pg[1].g
            | (pg[1].p & pg[0].g)
            | (pg[1].p & pg[0].p & CARRY_IN);
      gc[3] = pg[2].g
            | (pg[2].p & pg[1].g)
            | (pg[2].p & pg[1].p & pg[0].g)
            | (pg[2].p & pg[1].p & pg[0].p & CARRY_IN);
   end

   always_comb begin
      Sum  = sum_w;
      Cout = pg[3].g
           | (pg[3].p & pg[2].g)
           | (pg[3].p & pg[2].p & pg[1].g)
           | (pg[3].p & pg[2].p & pg[1].p & pg[0].g)
           | ((&{pg[3].p, pg[2].p, pg[1].p, pg[0].p}) & CARRY_IN);
      Ovfl = (A[DATA_W-1] == B[DATA_W-1])
           && (sum_w[DATA_W-1] != A[DATA_W-1]);
   end

   logic [DATA_W-1:0] sum_d;
   logic              cout_d;
   logic              ovfl_d;

   always_comb begin
      sum_d  = Sum;
      cout_d = Cout;
      ovfl_d = Ovfl;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         Sum_q  <= '0;
         Cout_q <= 1'b0;
         Ovfl_q <= 1'b0;
      end else begin
         Sum_q  <= sum_d;
         Cout_q <= cout_d;
         Ovfl_q <= ovfl_d;
      end
   end

endmodule

// File: tb/tb_cla_adder_16.sv
// Self-checking bench for cla_adder_16: arithmetic model,
// per-cycle compare process and literal directed vectors.
module tb_cla_adder_16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] A = '0;
   logic [15:0] B = '0;
   logic [15:0] Sum;
   logic        Cout;
   logic        Ovfl;
   logic [15:0] Sum_q;
   logic        Cout_q;
   logic        Ovfl_q;

   int n_tests = 0;
   int n_fail  = 0;

   always #11 clk = ~clk;

   cla_adder_16 dut (
      .clk    (clk),
      .rst    (rst),
      .A      (A),
      .B      (B),
      .Sum    (Sum),
      .Cout   (Cout),
      .Ovfl   (Ovfl),
      .Sum_q  (Sum_q),
      .Cout_q (Cout_q),
      .Ovfl_q (Ovfl_q)
   );

   // Returns {ovfl, cout, sum} from plain 17-bit arithmetic
   function automatic logic [17:0] model(input logic [15:0] a,
                                         input logic [15:0] b);
      logic [16:0] r;
      logic        ov;
      r  = {1'b0, a} + {1'b0, b};
      ov = (a[15] == b[15]) && (r[15] != a[15]);
      return {ov, r};
   endfunction

   task automatic chk(input string name,
                      input logic [17:0] got,
                      input logic [17:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s A=%h B=%h got {ovfl,cout,sum}=%h want %h",
                  name, A, B, got, want);
      end
   endtask

   // Inputs change 1 unit after posedge; sampled at the next negedge
   logic        pend_v = 1'b0;
   logic        pend_rst;
   logic [15:0] pend_a;
   logic [15:0] pend_b;

   always @(negedge clk) begin
      chk("comb", {Ovfl, Cout, Sum}, model(A, B));
      if (pend_v)
         chk("regd", {Ovfl_q, Cout_q, Sum_q},
             pend_rst ? 18'h0 : model(pend_a, pend_b));
      pend_v   <= 1'b1;
      pend_a   <= A;
      pend_b   <= B;
      pend_rst <= rst;
   end

   task automatic drive(input logic [15:0] a,
                        input logic [15:0] b,
                        input logic        r);
      @(posedge clk);
      #1;
      rst = r;
      A   = a;
      B   = b;
   endtask

   task automatic vec(input string name,
                      input logic [15:0] a,
                      input logic [15:0] b,
                      input logic [15:0] es,
                      input logic        ec,
                      input logic        eo);
      drive(a, b, 1'b0);
      @(negedge clk);
      chk(name, {Ovfl, Cout, Sum}, {eo, ec, es});
   endtask

   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_q", {Ovfl_q, Cout_q, Sum_q}, 18'h0);

      vec("ffff_p1",   16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0);
      vec("ffff_ffff", 16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b1, 1'b0);
      vec("grp0_bnd",  16'h000F, 16'h0001, 16'h0010, 1'b0, 1'b0);
      vec("grp1_bnd",  16'h00FF, 16'h0001, 16'h0100, 1'b0, 1'b0);
      vec("grp2_bnd",  16'h0FFF, 16'h0001, 16'h1000, 1'b0, 1'b0);
      vec("ovfl_pos",  16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1);
      vec("ovfl_neg",  16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1);
      vec("neg_mix",   16'h8000, 16'hFFFF, 16'h7FFF, 1'b1, 1'b1);

      vec("reg_in",    16'h1234, 16'h4321, 16'h5555, 1'b0, 1'b0);
      drive(16'h1234, 16'h4321, 1'b1);
      @(negedge clk);
      chk("reg_out", {Ovfl_q, Cout_q, Sum_q}, {2'b00, 16'h5555});
      drive(16'h1234, 16'h4321, 1'b1);
      @(negedge clk);
      chk("rst_mid_q", {Ovfl_q, Cout_q, Sum_q}, 18'h0);
      chk("rst_mid_s", {Ovfl, Cout, Sum}, {2'b00, 16'h5555});

      for (int a = 0; a < 256; a++)
         for (int b = 0; b < 64; b++)
            drive(16'(a), 16'(b), 1'b0);

      for (int i = 0; i < 20000; i++)
         drive(16'($urandom), 16'($urandom),
               $urandom_range(0, 15) == 0);

      @(negedge clk);
      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
